// File: rtl/uctl_cdc_arb_pkg.sv
// Shared types and constants for the clock1-side CDC event arbiter.
package uctl_cdc_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StGuard = 2'd2
  } arb_state_e;

  localparam int unsigned MinGuard = 2;

  // Ceiling log2, never below one bit.
  function automatic int unsigned clog2(input int unsigned val);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(val)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/uctl_cdc_event_arb_if.sv
// Requester and crossing-side signal bundle of uctl_cdc_event_arb.
interface uctl_cdc_event_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned ID_WD   = 2
);
  logic [NUM_REQ-1:0]         reqPulse;
  logic [NUM_REQ*DATA_WD-1:0] reqData;
  logic [NUM_REQ-1:0]         reqPending;
  logic [NUM_REQ-1:0]         dropErr;
  logic [NUM_REQ-1:0]         errClr;
  logic                       issuePulse;
  logic [DATA_WD-1:0]         issueData;
  logic [ID_WD-1:0]           issueId;
  logic                       busy;

  modport master (
    output reqPulse, reqData, errClr,
    input  reqPending, dropErr, issuePulse, issueData, issueId, busy
  );

  modport slave (
    input  reqPulse, reqData, errClr,
    output reqPending, dropErr, issuePulse, issueData, issueId, busy
  );
endinterface

// File: rtl/uctl_rr_pick.sv
// Combinational pick of one pending requester: round robin from ptr, or lowest index
// when UCTL_CDC_ARB_FIXED_PRIO_EN is defined.
module uctl_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_WD   = 2
) (
  input  logic [NUM_REQ-1:0] pending,
`ifndef UCTL_CDC_ARB_FIXED_PRIO_EN
  input  logic [ID_WD-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_WD-1:0]   idx,
  output logic               valid
);

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = |pending;
`ifdef UCTL_CDC_ARB_FIXED_PRIO_EN
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = ID_WD'(i);
      end
    end
`else
    // Walk from the farthest offset back to ptr so the nearest pending one wins.
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (pending[(int'(ptr) + k) % int'(NUM_REQ)]) begin
        grant = '0;
        grant[(int'(ptr) + k) % int'(NUM_REQ)] = 1'b1;
        idx   = ID_WD'((int'(ptr) + k) % int'(NUM_REQ));
      end
    end
`endif
  end

endmodule

// File: rtl/uctl_cdc_event_arb.sv
// Shares one pulse-stretch CDC crossing among NUM_REQ event sources, spacing issues by
// GUARD_CYCLES. Define UCTL_CDC_ARB_FIXED_PRIO_EN for fixed (lowest-index) priority.
module uctl_cdc_event_arb
  import uctl_cdc_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WD      = 8,
  parameter int unsigned ID_WD        = 2,
  parameter int unsigned GUARD_CYCLES = 8
) (
  input logic                 clock1,
  input logic                 clock1Rst_n,
  uctl_cdc_event_arb_if.slave bus
);

  localparam int unsigned CntWd = clog2(GUARD_CYCLES);

  if (GUARD_CYCLES < MinGuard) begin : g_guard_chk
    $error("GUARD_CYCLES below minimum");
  end

  arb_state_e                      state_q, state_d;
  logic [NUM_REQ-1:0]              pend_q, pend_d, drop_q, drop_d;
  logic [NUM_REQ-1:0]              grant, grant_mask, load;
  logic [NUM_REQ-1:0][DATA_WD-1:0] data_q;
  logic [ID_WD-1:0]                grant_idx, id_q;
  logic [DATA_WD-1:0]              grant_data, issue_data_q;
  logic [CntWd-1:0]                cnt_q, cnt_d;
  logic                            grant_valid, grant_en, load_cnt, busy, pulse_q;

`ifndef UCTL_CDC_ARB_FIXED_PRIO_EN
  logic [ID_WD-1:0] ptr_q, ptr_d;
`endif

  uctl_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_WD  (ID_WD)
  ) u_pick (
    .pending(pend_q),
`ifndef UCTL_CDC_ARB_FIXED_PRIO_EN
    .ptr    (ptr_q),
`endif
    .grant  (grant),
    .idx    (grant_idx),
    .valid  (grant_valid)
  );

  // A grant frees the slot in the same cycle, so a coincident new event re-captures cleanly.
  always_comb begin
    grant_mask = grant_en ? grant : '0;
    load       = bus.reqPulse & (~pend_q | grant_mask);
    pend_d     = (pend_q & ~grant_mask) | bus.reqPulse;
    drop_d     = (drop_q & ~bus.errClr) | (bus.reqPulse & pend_q & ~grant_mask);
    grant_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) grant_data = data_q[i];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_cnt) begin
      cnt_d = CntWd'(GUARD_CYCLES - MinGuard);
    end else if (state_q == StGuard && cnt_q != '0) begin
      cnt_d = cnt_q - CntWd'(1);
    end
  end

`ifndef UCTL_CDC_ARB_FIXED_PRIO_EN
  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) ptr_d = (grant_idx == ID_WD'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WD'(1);
  end
`endif

  // Leaving GUARD one count early keeps issue-to-issue spacing at GUARD_CYCLES with IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StIssue;
      StIssue: state_d = StGuard;
      StGuard: if (cnt_q <= CntWd'(1)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    grant_en = 1'b0;
    load_cnt = 1'b0;
    unique case (state_q)
      StIdle:  grant_en = grant_valid;
      StIssue: begin
        busy     = 1'b1;
        load_cnt = 1'b1;
      end
      StGuard: busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock1 or negedge clock1Rst_n) begin
    if (!clock1Rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock1 or negedge clock1Rst_n) begin
    if (!clock1Rst_n) begin
      pend_q       <= '0;
      drop_q       <= '0;
      data_q       <= '0;
      id_q         <= '0;
      issue_data_q <= '0;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
`ifndef UCTL_CDC_ARB_FIXED_PRIO_EN
      ptr_q        <= '0;
`endif
    end else begin
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      pulse_q <= load_cnt;
`ifndef UCTL_CDC_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (load[i]) data_q[i] <= bus.reqData[i*DATA_WD +: DATA_WD];
      end
      if (grant_en) begin
        id_q         <= grant_idx;
        issue_data_q <= grant_data;
      end
    end
  end

  assign bus.reqPending = pend_q;
  assign bus.dropErr    = drop_q;
  assign bus.issuePulse = pulse_q;
  assign bus.issueData  = issue_data_q;
  assign bus.issueId    = id_q;
  assign bus.busy       = busy;

endmodule

// File: tb/tb_uctl_cdc_event_arb.sv
// Bench for uctl_cdc_event_arb: timestamp-based reference model, directed and random stimulus.
module tb_uctl_cdc_event_arb;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int G  = 8;

  logic clock1      = 1'b0;
  logic clock1Rst_n = 1'b0;
  always #5 clock1 = ~clock1;

  uctl_cdc_event_arb_if #(.NUM_REQ(N), .DATA_WD(DW), .ID_WD(IW)) bus ();

  uctl_cdc_event_arb #(
    .NUM_REQ     (N),
    .DATA_WD     (DW),
    .ID_WD       (IW),
    .GUARD_CYCLES(G)
  ) dut (
    .clock1     (clock1),
    .clock1Rst_n(clock1Rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int failures = 0;
  int cur = 0;

  // Reference model: per-requester state plus timestamps of the next arbitration/pulse.
  logic [N-1:0]  m_pend, m_drop;
  logic [DW-1:0] m_data [N];
  logic [DW-1:0] m_idata;
  logic [IW-1:0] m_iid;
  int m_ptr, m_next_arb, m_pulse_cyc, m_busy_from, m_busy_to;

  int            obs_id [$];
  logic [DW-1:0] obs_data [$];
  int            obs_cyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cur, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_drop = '0;
    for (int i = 0; i < N; i++) m_data[i] = '0;
    m_idata     = '0;
    m_iid       = '0;
    m_ptr       = 0;
    m_next_arb  = cur;
    m_pulse_cyc = -1000;
    m_busy_from = cur + 1;
    m_busy_to   = cur;
  endtask

  task automatic model_step(input logic [N-1:0] p, input logic [N*DW-1:0] d,
                            input logic [N-1:0] c);
    logic [N-1:0] gm, dset;
    int g, j;
    gm = '0;
    dset = '0;
    if (cur >= m_next_arb && m_pend != '0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
`ifdef UCTL_CDC_ARB_FIXED_PRIO_EN
        j = k;
`else
        j = (m_ptr + k) % N;
`endif
        if (g < 0 && m_pend[j]) g = j;
      end
      gm[g]       = 1'b1;
      m_idata     = m_data[g];
      m_iid       = IW'(g);
      m_ptr       = (g + 1) % N;
      m_pulse_cyc = cur + 2;
      m_busy_from = cur + 1;
      m_busy_to   = cur + G - 1;
      m_next_arb  = cur + G;
    end
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        if (!m_pend[i] || gm[i]) begin
          m_pend[i] = 1'b1;
          m_data[i] = d[i*DW +: DW];
        end else begin
          dset[i] = 1'b1;
        end
      end else if (gm[i]) begin
        m_pend[i] = 1'b0;
      end
    end
    m_drop = (m_drop & ~c) | dset;
    cur++;
  endtask

  task automatic compare_all();
    check("reqPending", 32'(bus.reqPending), 32'(m_pend));
    check("dropErr", 32'(bus.dropErr), 32'(m_drop));
    check("issuePulse", 32'(bus.issuePulse), 32'(cur == m_pulse_cyc));
    check("issueData", 32'(bus.issueData), 32'(m_idata));
    check("issueId", 32'(bus.issueId), 32'(m_iid));
    check("busy", 32'(bus.busy), 32'(cur >= m_busy_from && cur <= m_busy_to));
    if (bus.issuePulse === 1'b1) begin
      obs_id.push_back(int'(bus.issueId));
      obs_data.push_back(bus.issueData);
      obs_cyc.push_back(cur);
    end
  endtask

  task automatic step(input logic [N-1:0] p, input logic [N*DW-1:0] d, input logic [N-1:0] c);
    bus.reqPulse = p;
    bus.reqData  = d;
    bus.errClr   = c;
    @(posedge clock1);
    model_step(p, d, c);
    @(negedge clock1);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0);
  endtask

  // Called at a negedge: asserts reset mid-cycle and expects outputs to clear at once.
  task automatic do_reset();
    #2;
    clock1Rst_n  = 1'b0;
    bus.reqPulse = '0;
    bus.reqData  = '0;
    bus.errClr   = '0;
    #1;
    check("rst_reqPending", 32'(bus.reqPending), 32'h0);
    check("rst_dropErr", 32'(bus.dropErr), 32'h0);
    check("rst_issuePulse", 32'(bus.issuePulse), 32'h0);
    check("rst_issueData", 32'(bus.issueData), 32'h0);
    check("rst_issueId", 32'(bus.issueId), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    @(negedge clock1);
    clock1Rst_n = 1'b1;
    model_reset();
    compare_all();
    obs_id.delete();
    obs_data.delete();
    obs_cyc.delete();
  endtask

  task automatic wait_issues(input int n, input int max_cycles);
    for (int i = 0; i < max_cycles && obs_id.size() < n; i++) idle(1);
    check("issue_timeout", 32'(obs_id.size() >= n), 32'h1);
  endtask

  initial begin
    int exp3 [6];
    logic [N-1:0] p;
    bus.reqPulse = '0;
    bus.reqData  = '0;
    bus.errClr   = '0;
    model_reset();
    @(negedge clock1);
    do_reset();
    cur = 0;
    model_reset();

    // Single event on requester 2.
    idle(10);
    step(4'b0100, 32'h00A5_0000, '0);
    check("t1_pending", 32'(bus.reqPending), 32'h4);
    idle(1);
    check("t1_busy_issue", 32'(bus.busy), 32'h1);
    check("t1_no_pulse_yet", 32'(bus.issuePulse), 32'h0);
    idle(1);
    check("t1_cycle", 32'(cur), 32'd13);
    check("t1_pulse", 32'(bus.issuePulse), 32'h1);
    check("t1_data", 32'(bus.issueData), 32'hA5);
    check("t1_id", 32'(bus.issueId), 32'h2);
    idle(5);
    check("t1_busy_last", 32'(bus.busy), 32'h1);
    idle(1);
    check("t1_busy_low", 32'(bus.busy), 32'h0);

    // All four at once.
    do_reset();
    step(4'b1111, 32'h1312_1110, '0);
    wait_issues(4, 40);
    check("t2_count", 32'(obs_id.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_id.size(); i++) begin
      check("t2_id", 32'(obs_id[i]), 32'(i));
      check("t2_data", 32'(obs_data[i]), 32'h10 + 32'(i));
      if (i + 1 < obs_cyc.size()) check("t2_spacing", 32'(obs_cyc[i+1] - obs_cyc[i]), 32'd8);
    end

    // Continuous load on requesters 1 and 3.
`ifdef UCTL_CDC_ARB_FIXED_PRIO_EN
    exp3 = '{1, 1, 1, 1, 1, 1};
`else
    exp3 = '{1, 3, 1, 3, 1, 3};
`endif
    do_reset();
    step(4'b0010, 32'h0000_3100, '0);
    for (int i = 0; i < 80 && obs_id.size() < 6; i++) begin
      p = {~m_pend[3], 1'b0, ~m_pend[1], 1'b0};
      step(p, $urandom, '0);
    end
    check("t3_count", 32'(obs_id.size() >= 6), 32'h1);
    for (int i = 0; i < 6 && i < obs_id.size(); i++) check("t3_id", 32'(obs_id[i]), 32'(exp3[i]));

    // Drop on requester 0 while it waits behind requester 1.
    do_reset();
    step(4'b0010, 32'h0000_3100, '0);
    idle(1);
    step(4'b0001, 32'h0000_0055, '0);
    idle(1);
    step(4'b0001, 32'h0000_0066, '0);
    check("t4_drop", 32'(bus.dropErr), 32'h1);
    check("t4_pending", 32'(bus.reqPending), 32'h1);
    wait_issues(2, 30);
    if (obs_id.size() >= 2) begin
      check("t4_id0", 32'(obs_id[0]), 32'h1);
      check("t4_data0", 32'(obs_data[0]), 32'h31);
      check("t4_id1", 32'(obs_id[1]), 32'h0);
      check("t4_data1", 32'(obs_data[1]), 32'h55);
    end
    step('0, '0, 4'b0001);
    check("t4_clr", 32'(bus.dropErr), 32'h0);

    // New event on requester 1 in its own grant cycle.
    do_reset();
    step(4'b0010, 32'h0000_2100, '0);
    step(4'b0010, 32'h0000_2200, '0);
    check("t5_nodrop", 32'(bus.dropErr), 32'h0);
    check("t5_pending", 32'(bus.reqPending), 32'h2);
    wait_issues(2, 30);
    if (obs_id.size() >= 2) begin
      check("t5_data0", 32'(obs_data[0]), 32'h21);
      check("t5_id1", 32'(obs_id[1]), 32'h1);
      check("t5_data1", 32'(obs_data[1]), 32'h22);
      check("t5_spacing", 32'(obs_cyc[1] - obs_cyc[0]), 32'd8);
    end

    // Reset during GUARD with requester 2 pending.
    do_reset();
    step(4'b0010, 32'h0000_4400, '0);
    idle(2);
    step(4'b0100, 32'h0077_0000, '0);
    idle(1);
    check("t6_pending", 32'(bus.reqPending), 32'h4);
    check("t6_busy", 32'(bus.busy), 32'h1);
    do_reset();
    idle(30);
    check("t6_no_issue", 32'(obs_id.size()), 32'd0);

    // Random traffic with occasional mid-run resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom) & 4'($urandom), $urandom, 4'($urandom) & 4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cur);
    $fatal(1, "watchdog");
  end

endmodule
